// File: rtl/tempsense_pkg.sv
// Shared constants for the tempsense SAR controller: FSM state codes,
// DAC full-scale helpers and the conversion latency formula.
package tempsense_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_PRECHARGE  = 3'd1;
  localparam logic [2:0] ST_TRANSITION = 3'd2;
  localparam logic [2:0] ST_MEASURE    = 3'd3;
  localparam logic [2:0] ST_EVALUATE   = 3'd4;
  localparam logic [2:0] ST_ACCUM      = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;

  localparam int unsigned VMIN = 0;

  function automatic int unsigned vmax(input int unsigned n);
    return (1 << n) - 1;
  endfunction

  // Cycles from the IDLE cycle that samples i_start up to and
  // including the DONE cycle that carries o_valid.
  function automatic int unsigned conv_latency(
    input int unsigned n_vdac,
    input int unsigned avg_log2,
    input int unsigned n_settle
  );
    return 1 + (1 << avg_log2) * (n_vdac * (n_settle + 3) + 1) + 1;
  endfunction

endpackage

// File: rtl/tempsense_cal_lut.sv
// Calibration LUT: serial word loader, auto-incrementing write pointer,
// 2**N_VDAC x N_VDAC RAM (not reset) and a combinational read port.
// Ports: clk, reset (sync, active-high); i_cal_dat/i_cal_shift shift a
// word in MSB first; i_cal_ld writes it to mem[wr_ptr] and advances the
// pointer; i_addr -> o_data is the lookup.
module tempsense_cal_lut
  import tempsense_pkg::*;
#(
  parameter int N_VDAC = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cal_dat,
  input  logic              i_cal_shift,
  input  logic              i_cal_ld,
  input  logic [N_VDAC-1:0] i_addr,
  output logic [N_VDAC-1:0] o_data
);

  localparam int DEPTH = 1 << N_VDAC;

  logic [N_VDAC-1:0] r_word;
  logic [N_VDAC-1:0] r_wr_ptr;
  logic [N_VDAC-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word   <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (i_cal_shift)
        r_word <= {r_word[N_VDAC-2:0], i_cal_dat};
      if (i_cal_ld)
        r_wr_ptr <= r_wr_ptr + N_VDAC'(1);
    end
  end

  // A load in the same cycle as a shift stores the pre-shift word.
  always_ff @(posedge clk) begin
    if (i_cal_ld && !reset)
      r_mem[r_wr_ptr] <= r_word;
  end

  assign o_data = r_mem[i_addr];

endmodule

// File: rtl/tempsense_sar_ctrl.sv
// Successive-approximation controller for the tempsense delay line.
// Runs N_VDAC binary-search trials per conversion, averages
// 2**AVG_LOG2 conversions and presents the result with a one-cycle
// o_valid pulse. Single-shot via i_start, continuous via i_cont.
// Ports: clk, reset (sync, active-high); i_start, i_cont, o_busy,
// o_valid, o_result (handshake/result); o_dac_data, o_dac_en,
// o_precharge_n, i_tempdelay (tempsense core); i_cal_dat, i_cal_shift,
// i_cal_ld (LUT loader, used only with TEMPSENSE_CAL_LUT_EN defined).
module tempsense_sar_ctrl
  import tempsense_pkg::*;
#(
  parameter int N_VDAC   = 6,
  parameter int AVG_LOG2 = 2,
  parameter int N_SETTLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_cont,
  output logic              o_busy,
  output logic              o_valid,
  output logic [N_VDAC-1:0] o_result,
  output logic [N_VDAC-1:0] o_dac_data,
  output logic              o_dac_en,
  output logic              o_precharge_n,
  input  logic              i_tempdelay,
  input  logic              i_cal_dat,
  input  logic              i_cal_shift,
  input  logic              i_cal_ld
);

  localparam int AW = N_VDAC + AVG_LOG2;
  localparam int BW = (N_VDAC > 1) ? $clog2(N_VDAC) : 1;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = $clog2(N_SETTLE + 1);

  localparam logic [N_VDAC-1:0] DAC_MAX = N_VDAC'(vmax(N_VDAC));
  localparam logic [N_VDAC-1:0] DAC_MIN = N_VDAC'(VMIN);
  localparam logic [N_VDAC-1:0] DAC_ONE = N_VDAC'(1);
  localparam logic [BW-1:0] BIT_TOP = BW'(N_VDAC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [SW-1:0] SET_LAST = SW'(N_SETTLE - 1);

  logic [2:0]        r_state;
  logic [N_VDAC-1:0] r_trial;
  logic [BW-1:0]     r_bit;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_acc;
  logic [SW-1:0]     r_settle;
  logic [N_VDAC-1:0] r_result;
  logic              r_valid;

  logic [N_VDAC-1:0] w_probe;
  logic [AW-1:0]     w_acc_sum;
  logic [N_VDAC-1:0] w_avg;
  logic [N_VDAC-1:0] w_final;
  logic [N_VDAC-1:0] w_dac;
  logic              w_en;
  logic              w_pn;

  assign w_probe   = r_trial | (DAC_ONE << r_bit);
  assign w_acc_sum = r_acc + AW'(r_trial);
  assign w_avg     = w_acc_sum[AW-1:AVG_LOG2];

`ifdef TEMPSENSE_CAL_LUT_EN
  tempsense_cal_lut #(
    .N_VDAC(N_VDAC)
  ) u_cal_lut (
    .clk        (clk),
    .reset      (reset),
    .i_cal_dat  (i_cal_dat),
    .i_cal_shift(i_cal_shift),
    .i_cal_ld   (i_cal_ld),
    .i_addr     (w_avg),
    .o_data     (w_final)
  );
`else
  assign w_final = w_avg;
  logic w_unused_cal;
  assign w_unused_cal = &{1'b0, i_cal_dat, i_cal_shift, i_cal_ld};
`endif

  // o_result/o_valid are loaded on the ACCUM->DONE edge from the final
  // sum, so both are visible together during the DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_trial  <= '0;
      r_bit    <= BIT_TOP;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_settle <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start || i_cont) begin
            r_state <= ST_PRECHARGE;
            r_trial <= '0;
            r_bit   <= BIT_TOP;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        ST_PRECHARGE: r_state <= ST_TRANSITION;
        ST_TRANSITION: begin
          r_state  <= ST_MEASURE;
          r_settle <= '0;
        end
        ST_MEASURE: begin
          if (r_settle == SET_LAST)
            r_state <= ST_EVALUATE;
          else
            r_settle <= r_settle + SW'(1);
        end
        ST_EVALUATE: begin
          // Delay line still fast enough: dac not above the threshold.
          r_trial[r_bit] <= ~i_tempdelay;
          if (r_bit == '0) begin
            r_state <= ST_ACCUM;
          end else begin
            r_bit   <= r_bit - BW'(1);
            r_state <= ST_PRECHARGE;
          end
        end
        ST_ACCUM: begin
          r_acc <= w_acc_sum;
          if (r_cnt == CNT_LAST) begin
            r_state  <= ST_DONE;
            r_result <= w_final;
            r_valid  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_trial <= '0;
            r_bit   <= BIT_TOP;
            r_state <= ST_PRECHARGE;
          end
        end
        ST_DONE: begin
          if (i_cont) begin
            r_state <= ST_PRECHARGE;
            r_trial <= '0;
            r_bit   <= BIT_TOP;
            r_cnt   <= '0;
            r_acc   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dac = DAC_MAX;
    w_en  = 1'b1;
    w_pn  = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE): w_en = 1'b0;
      (r_state == ST_TRANSITION): w_dac = DAC_MIN;
      (r_state == ST_MEASURE),
      (r_state == ST_EVALUATE): begin
        w_dac = w_probe;
        w_pn  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_busy        = (r_state != ST_IDLE);
  assign o_valid       = r_valid;
  assign o_result      = r_result;
  assign o_dac_data    = w_dac;
  assign o_dac_en      = w_en;
  assign o_precharge_n = w_pn;

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Directed + randomized bench for tempsense_sar_ctrl with a threshold
// model of the delay line and an arithmetic reference for results.
module tb_tempsense_sar_ctrl;

  localparam int N    = 6;
  localparam int AVG  = 2;
  localparam int SET  = 1;
  localparam int NAVG = 1 << AVG;
  localparam int CONV = N * (SET + 3) + 1;
  localparam int LAT  = 1 + NAVG * CONV + 1;
  localparam int PER  = NAVG * CONV + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_start = 1'b0;
  logic i_cont = 1'b0;
  logic i_cal_dat = 1'b0;
  logic i_cal_shift = 1'b0;
  logic i_cal_ld = 1'b0;
  logic i_tempdelay;
  logic o_busy, o_valid, o_dac_en, o_precharge_n;
  logic [N-1:0] o_result, o_dac_data;

  int checks = 0;
  int failures = 0;
  int cur_thr = 0;
  int thr_tab[NAVG];
  int trials = 0;
  logic pn_prev = 1'b0;
  int probes[$];
  int exp_lut[1 << N];

  tempsense_sar_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_cont       (i_cont),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_dac_data   (o_dac_data),
    .o_dac_en     (o_dac_en),
    .o_precharge_n(o_precharge_n),
    .i_tempdelay  (i_tempdelay),
    .i_cal_dat    (i_cal_dat),
    .i_cal_shift  (i_cal_shift),
    .i_cal_ld     (i_cal_ld)
  );

  always #50 clk = ~clk;

  // Delay line model: slow (1) once the DAC exceeds the threshold.
  assign i_tempdelay = (int'(o_dac_data) > cur_thr);

  // Each precharge_n rise marks a new trial; pick that conversion's
  // threshold and log the probed DAC code.
  always @(negedge clk) begin
    if (o_precharge_n && !pn_prev) begin
      trials++;
      cur_thr = thr_tab[((trials - 1) / N) % NAVG];
      probes.push_back(int'(o_dac_data));
    end
    pn_prev = o_precharge_n;
  end

  initial begin
    #(100 * 30000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // k-th probe of a binary search for the largest code <= thr.
  function automatic int sar_probe(input int thr, input int k);
    int t, p;
    t = 0;
    p = 0;
    for (int j = 0; j <= k; j++) begin
      p = t | (1 << (N - 1 - j));
      if (p <= thr) t = p;
    end
    return p;
  endfunction

  task automatic set_thr(input int a, b, c, d);
    thr_tab[0] = a;
    thr_tab[1] = b;
    thr_tab[2] = c;
    thr_tab[3] = d;
    trials = 0;
    probes.delete();
  endtask

  task automatic wait_valid(output int n, input int bound);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < bound);
  endtask

  task automatic run_one(input int a, b, c, d, input bit poke,
                         input string tag);
    int n, expv;
    set_thr(a, b, c, d);
    expv = exp_lut[(a + b + c + d) / NAVG];
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 1;
    chk({tag, "_busy"}, o_busy, 1);
    while (!o_valid && n < LAT + 50) begin
      i_start = (poke && n == 30);
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    chk({tag, "_lat"}, n, LAT - 1);
    chk({tag, "_res"}, o_result, expv);
    chk({tag, "_ntrial"}, probes.size(), N * NAVG);
    for (int k = 0; k < N && k < probes.size(); k++)
      chk({tag, "_probe"}, probes[k], sar_probe(a, k));
    @(negedge clk);
    chk({tag, "_vld_end"}, o_valid, 0);
    chk({tag, "_idle"}, o_busy, 0);
  endtask

`ifdef TEMPSENSE_CAL_LUT_EN
  task automatic shift_word(input int w);
    for (int b = N - 1; b >= 0; b--) begin
      @(negedge clk);
      i_cal_dat = w[b];
      i_cal_shift = 1'b1;
    end
    @(negedge clk);
    i_cal_shift = 1'b0;
  endtask
`endif

  initial begin
    int n, nv;
    for (int i = 0; i < (1 << N); i++) exp_lut[i] = i;
    set_thr(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_dac_en", o_dac_en, 0);
    chk("rst_dac", o_dac_data, (1 << N) - 1);
    chk("rst_pn", o_precharge_n, 0);
    reset = 1'b0;

    // Abort in EVALUATE of the second trial.
    set_thr(37, 37, 37, 37);
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abt_pn", o_precharge_n, 1);
    chk("abt_dac", o_dac_data, sar_probe(37, 1));
    reset = 1'b1;
    @(negedge clk);
    chk("abt_busy", o_busy, 0);
    chk("abt_en", o_dac_en, 0);
    chk("abt_valid", o_valid, 0);
    chk("abt_result", o_result, 0);
    reset = 1'b0;
    nv = 0;
    repeat (LAT + 20) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    chk("abt_novalid", nv, 0);

`ifdef TEMPSENSE_CAL_LUT_EN
    for (int i = 0; i < (1 << N); i++) begin
      shift_word((1 << N) - 1 - i);
      i_cal_ld = 1'b1;
      @(negedge clk);
      i_cal_ld = 1'b0;
      exp_lut[i] = (1 << N) - 1 - i;
    end
    run_one(10, 10, 10, 10, 1'b0, "lut10");
    chk("lut10_53", o_result, 53);
    // Pointer has wrapped to 0; load 5 while shifting another bit in.
    shift_word(5);
    @(negedge clk);
    i_cal_dat = 1'b1;
    i_cal_shift = 1'b1;
    i_cal_ld = 1'b1;
    @(negedge clk);
    i_cal_shift = 1'b0;
    i_cal_ld = 1'b0;
    i_cal_dat = 1'b0;
    exp_lut[0] = 5;
    run_one(0, 0, 0, 0, 1'b0, "lut_pre");
`endif

    run_one(37, 37, 37, 37, 1'b0, "t37");
    run_one(20, 21, 22, 23, 1'b0, "t20_23");
    run_one(0, 63, 0, 63, 1'b0, "edge");
    run_one(50, 12, 33, 7, 1'b1, "poke");
    for (int r = 0; r < 4; r++)
      run_one($urandom_range(0, 63), $urandom_range(0, 63),
              $urandom_range(0, 63), $urandom_range(0, 63),
              1'b0, "rand");

    // Continuous mode.
    set_thr(63, 63, 63, 63);
    @(negedge clk);
    i_cont = 1'b1;
    wait_valid(n, LAT + 50);
    chk("cont_first", n, LAT - 1);
    chk("cont_res", o_result, exp_lut[63]);
    for (int p = 0; p < 2; p++) begin
      wait_valid(n, PER + 50);
      chk("cont_period", n, PER);
      chk("cont_res", o_result, exp_lut[63]);
    end
    @(negedge clk);
    i_cont = 1'b0;
    nv = 0;
    repeat (PER + 50) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    chk("cont_tail", nv, 1);
    chk("cont_idle", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
